// File: rtl/msg_txn_ctrl.sv
// Host-side transaction controller: word-level send/receive requests become a byte-serial
// token / data / handshake exchange with one addressed device, with NAK retry and rx timeout.
module msg_txn_ctrl #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned TIMEOUT_CYC = 32,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_byte,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte
);

  localparam int unsigned NBytes   = DATA_W / 8;
  localparam int unsigned ByteCntW = $clog2(NBytes + 1);
  localparam int unsigned IdleCntW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned AttemptW = $clog2(MAX_RETRY + 1) + 1;

  localparam logic [7:0] Ack = 8'hD2;
  localparam logic [7:0] Nak = 8'h5A;

  typedef enum logic [2:0] {
    StIdle,
    StToken,
    StTxData,
    StWaitHs,
    StRxData,
    StSendAck,
    StRetry,
    StDone
  } state_e;

  state_e              state_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   rx_q;
  logic [ByteCntW-1:0] byte_cnt_q;
  logic [IdleCntW-1:0] idle_cnt_q;
  logic [AttemptW-1:0] attempt_q;
  logic                tx_valid_q;
  logic [7:0]          tx_byte_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_timeout_q;

  logic                tx_fire;
  logic                idle_expired;
  logic                last_byte;
  logic [ByteCntW-1:0] next_idx;
  logic [DATA_W-1:0]   rx_ext;
  logic [DATA_W-1:0]   rx_shift;

  assign tx_fire      = tx_valid_q & tx_ready;
  assign idle_expired = (idle_cnt_q == IdleCntW'(TIMEOUT_CYC - 1));
  assign last_byte    = (byte_cnt_q == ByteCntW'(NBytes - 1));
  assign next_idx     = byte_cnt_q + ByteCntW'(1);
  assign rx_ext       = DATA_W'(rx_byte);
  // Bytes arrive LSB first: shift in from the top so the first byte ends at bit 0.
  assign rx_shift     = (rx_q >> 8) | (rx_ext << (DATA_W - 8));

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q       <= StIdle;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      rx_q          <= '0;
      byte_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      attempt_q     <= '0;
      tx_valid_q    <= 1'b0;
      tx_byte_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            wr_q       <= req_write;
            addr_q     <= req_addr;
            data_q     <= req_data;
            attempt_q  <= '0;
            tx_valid_q <= 1'b1;
            tx_byte_q  <= {req_write, 7'(req_addr)};
            state_q    <= StToken;
          end
        end
        StToken: begin
          if (tx_fire) begin
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
            rx_q       <= '0;
            if (wr_q) begin
              tx_byte_q <= data_q[7:0];
              state_q   <= StTxData;
            end else begin
              tx_valid_q <= 1'b0;
              tx_byte_q  <= '0;
              state_q    <= StRxData;
            end
          end
        end
        StTxData: begin
          if (tx_fire) begin
            if (last_byte) begin
              tx_valid_q <= 1'b0;
              tx_byte_q  <= '0;
              idle_cnt_q <= '0;
              state_q    <= StWaitHs;
            end else begin
              byte_cnt_q <= next_idx;
              tx_byte_q  <= data_q[{next_idx, 3'b000} +: 8];
            end
          end
        end
        StWaitHs: begin
          // A byte arriving on the expiry cycle still counts as the handshake.
          if (rx_valid) begin
            idle_cnt_q <= '0;
            if (rx_byte == Ack) begin
              rsp_valid_q   <= 1'b1;
              rsp_timeout_q <= 1'b0;
              rsp_data_q    <= '0;
              state_q       <= StDone;
            end else begin
              state_q <= StRetry;
            end
          end else if (idle_expired) begin
            state_q <= StRetry;
          end else begin
            idle_cnt_q <= idle_cnt_q + IdleCntW'(1);
          end
        end
        StRxData: begin
          if (rx_valid) begin
            idle_cnt_q <= '0;
            rx_q       <= rx_shift;
            if (last_byte) begin
              tx_valid_q <= 1'b1;
              tx_byte_q  <= Ack;
              state_q    <= StSendAck;
            end else begin
              byte_cnt_q <= next_idx;
            end
          end else if (idle_expired) begin
            state_q <= StRetry;
          end else begin
            idle_cnt_q <= idle_cnt_q + IdleCntW'(1);
          end
        end
        StSendAck: begin
          if (tx_fire) begin
            tx_valid_q    <= 1'b0;
            tx_byte_q     <= '0;
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b0;
            rsp_data_q    <= rx_q;
            state_q       <= StDone;
          end
        end
        StRetry: begin
          rx_q <= '0;
          if (attempt_q < AttemptW'(MAX_RETRY)) begin
            attempt_q  <= attempt_q + AttemptW'(1);
            tx_valid_q <= 1'b1;
            tx_byte_q  <= {wr_q, 7'(addr_q)};
            state_q    <= StToken;
          end else begin
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_data_q    <= '0;
            state_q       <= StDone;
          end
        end
        StDone: begin
          rsp_valid_q   <= 1'b0;
          rsp_timeout_q <= 1'b0;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign tx_valid    = tx_valid_q;
  assign tx_byte     = tx_byte_q;

endmodule

// File: tb/tb_msg_txn_ctrl.sv
// Self-checking bench for msg_txn_ctrl: a scripted device answers on the byte link and the
// transmitted byte stream and response are compared against a transaction-level model.
module tb_msg_txn_ctrl;

  localparam int DW = 64;
  localparam int AW = 7;
  localparam int TO = 16;
  localparam int MR = 3;
  localparam int NB = DW / 8;
  localparam logic [7:0] ACK = 8'hD2;
  localparam logic [7:0] NAK = 8'h5A;

  logic clk = 1'b0;
  logic rst_L = 1'b0;

  logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          rsp_valid, rsp_timeout;
  logic [DW-1:0] rsp_data;
  logic          tx_valid, tx_ready = 1'b0;
  logic [7:0]    tx_byte;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = '0;

  logic          s_req_valid = 1'b0, s_req_ready, s_req_write = 1'b0;
  logic [3:0]    s_req_addr = '0;
  logic [15:0]   s_req_data = '0;
  logic          s_rsp_valid, s_rsp_timeout;
  logic [15:0]   s_rsp_data;
  logic          s_tx_valid, s_tx_ready = 1'b0;
  logic [7:0]    s_tx_byte;
  logic          s_rx_valid = 1'b0;
  logic [7:0]    s_rx_byte = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  msg_txn_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TO), .MAX_RETRY(MR)) u_dut (
    .clk(clk), .rst_L(rst_L),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte),
    .rx_valid(rx_valid), .rx_byte(rx_byte)
  );

  msg_txn_ctrl #(.DATA_W(16), .ADDR_W(4), .TIMEOUT_CYC(TO), .MAX_RETRY(MR)) u_dut16 (
    .clk(clk), .rst_L(rst_L),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_write(s_req_write),
    .req_addr(s_req_addr), .req_data(s_req_data),
    .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data), .rsp_timeout(s_rsp_timeout),
    .tx_valid(s_tx_valid), .tx_ready(s_tx_ready), .tx_byte(s_tx_byte),
    .rx_valid(s_rx_valid), .rx_byte(s_rx_byte)
  );

  // Drives one transaction on the 64-bit DUT; the device side is a small script, the expected
  // byte stream and response come from the attempt-level rules.
  task automatic run_txn(input string name, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [DW-1:0] rdata,
                         input int naks, input bit silent, input bit bp, output int lat);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int tok_pos[$];
    int attempts, phase, gap, cnt, nak_left, wait_n, first_bad;
    bit exp_to, done, stalled, got_to;
    logic [7:0] tok, held;
    logic [DW-1:0] exp_data, got_data;

    tok = {wr, addr};
    exp_to = silent || (naks > MR);
    attempts = exp_to ? MR + 1 : naks + 1;
    for (int a = 0; a < attempts; a++) begin
      exp_q.push_back(tok);
      if (wr) for (int b = 0; b < NB; b++) exp_q.push_back(data[8*b +: 8]);
    end
    if (!wr && !exp_to) exp_q.push_back(ACK);
    exp_data = (!wr && !exp_to) ? rdata : '0;
    lat = -1;

    wait_n = 0;
    while (!req_ready && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL %s req_ready_wait: got req_ready=%b want 1", name, req_ready);
      return;
    end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_data = data; tx_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_addr = ~addr; req_data = ~data;

    phase = 0; gap = 0; cnt = 0; nak_left = naks; done = 0; stalled = 0; held = '0;
    got_to = 0; got_data = '0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (i > 0) @(negedge clk);
      rx_valid = 1'b0;
      if (rsp_valid) begin
        done = 1; lat = i; got_to = rsp_timeout; got_data = rsp_data;
      end else begin
        if (stalled) begin
          total++;
          if (!(tx_valid === 1'b1 && tx_byte === held)) begin
            bad++;
            $display("FAIL %s stall_hold: got valid=%b byte=%h want valid=1 byte=%h",
                     name, tx_valid, tx_byte, held);
          end
        end
        if (gap > 0) gap--;
        else if (!silent && phase == 2) begin
          rx_byte = (nak_left > 0) ? NAK : ACK;
          rx_valid = 1'b1;
          if (nak_left > 0) nak_left--;
          phase = 0;
        end else if (!silent && phase == 3) begin
          rx_byte = rdata[8*cnt +: 8];
          rx_valid = 1'b1;
          cnt++;
          if (cnt == NB) phase = 4;
          gap = bp ? $urandom_range(0, 3) : 0;
        end
        tx_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        stalled = tx_valid && !tx_ready;
        held = tx_byte;
        if (tx_valid && tx_ready) begin
          got_q.push_back(tx_byte);
          if (phase == 1) begin
            cnt++;
            if (cnt == NB) begin
              phase = 2;
              gap = bp ? $urandom_range(0, 3) : 0;
            end
          end else if (phase != 4) begin
            tok_pos.push_back(i);
            cnt = 0;
            phase = wr ? 1 : 3;
            gap = bp ? $urandom_range(0, 3) : 0;
          end
        end
      end
    end
    rx_valid = 1'b0;
    tx_ready = 1'b0;

    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s rsp_valid_wait: got no rsp_valid within bound, want one pulse", name);
      return;
    end
    total++;
    first_bad = -1;
    if (got_q.size() == exp_q.size()) begin
      for (int k = 0; k < exp_q.size(); k++)
        if (first_bad < 0 && got_q[k] !== exp_q[k]) first_bad = k;
    end else first_bad = 0;
    if (first_bad >= 0) begin
      bad++;
      $display("FAIL %s tx_stream: got %0d bytes (byte%0d=%h) want %0d bytes (byte%0d=%h)",
               name, got_q.size(), first_bad,
               (first_bad < got_q.size()) ? got_q[first_bad] : 8'hxx,
               exp_q.size(), first_bad, exp_q[first_bad]);
    end
    total++;
    if (got_to !== exp_to) begin
      bad++;
      $display("FAIL %s rsp_timeout: got %b want %b", name, got_to, exp_to);
    end
    total++;
    if (got_data !== exp_data) begin
      bad++;
      $display("FAIL %s rsp_data: got %h want %h", name, got_data, exp_data);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s after_done: got rsp_valid=%b req_ready=%b want 0 1",
               name, rsp_valid, req_ready);
    end
    if (silent && !bp) begin
      for (int k = 1; k < tok_pos.size(); k++) begin
        total++;
        if (tok_pos[k] - tok_pos[k-1] < TO + 1 || tok_pos[k] - tok_pos[k-1] > TO + 3) begin
          bad++;
          $display("FAIL %s token_gap: got %0d cycles want %0d..%0d",
                   name, tok_pos[k] - tok_pos[k-1], TO + 1, TO + 3);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_L = 1'b0;
    @(negedge clk);
    total++;
    if (tx_valid !== 1'b0 || tx_byte !== 8'h00 || rsp_valid !== 1'b0 ||
        rsp_data !== '0 || rsp_timeout !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got txv=%b txb=%h rspv=%b rspd=%h rspto=%b want all 0",
               tx_valid, tx_byte, rsp_valid, rsp_data, rsp_timeout);
    end
    rst_L = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || s_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b/%b want 1/1", req_ready, s_req_ready);
    end
  endtask

  task automatic test_write();
    int lat;
    run_txn("write", 1'b1, 7'h00, 64'hcafefadedeadbeef, '0, 0, 1'b0, 1'b0, lat);
    total++;
    if (lat != 1 + NB + 1) begin
      bad++;
      $display("FAIL write_latency: got %0d cycles want %0d", lat, 1 + NB + 1);
    end
  endtask

  task automatic test_read();
    int lat;
    run_txn("read", 1'b0, 7'h05, '0, 64'h1234abcd5678efff, 0, 1'b0, 1'b0, lat);
  endtask

  task automatic test_retry();
    int lat;
    run_txn("retry", 1'b1, 7'h00, 64'h0123456789abcdef, '0, 2, 1'b0, 1'b0, lat);
  endtask

  task automatic test_exhaust();
    int lat;
    run_txn("exhaust", 1'b0, 7'h33, '0, 64'hffffffffffffffff, 0, 1'b1, 1'b0, lat);
  endtask

  task automatic test_backpressure_reset();
    logic [DW-1:0] d;
    int lat;
    d = 64'h8877665544332211;
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h11; req_data = d; tx_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_ready = 1'b1;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (tx_valid !== 1'b1 || tx_byte !== d[23:16]) begin
        bad++;
        $display("FAIL bp_stall%0d: got valid=%b byte=%h want 1 %h", i, tx_valid, tx_byte,
                 d[23:16]);
      end
      tx_ready = (i == 2);
      @(negedge clk);
    end
    total++;
    if (tx_valid !== 1'b1 || tx_byte !== d[31:24]) begin
      bad++;
      $display("FAIL bp_advance: got valid=%b byte=%h want 1 %h", tx_valid, tx_byte, d[31:24]);
    end
    tx_ready = 1'b0;
    #2 rst_L = 1'b0;
    #1;
    total++;
    if (tx_valid !== 1'b0 || tx_byte !== 8'h00 || rsp_valid !== 1'b0 ||
        rsp_data !== '0 || rsp_timeout !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs: got txv=%b txb=%h rspv=%b rspd=%h rspto=%b want all 0",
               tx_valid, tx_byte, rsp_valid, rsp_data, rsp_timeout);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL midreset_rsp: got rsp_valid=%b want 0", rsp_valid);
      end
    end
    rst_L = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL release_idle: got req_ready=%b tx_valid=%b want 1 0", req_ready, tx_valid);
    end
    run_txn("post_reset", 1'b1, 7'h11, d, '0, 0, 1'b0, 1'b0, lat);
  endtask

  task automatic test_param16();
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit done, sent_ack, ok;
    exp_q.push_back({1'b1, 3'b000, 4'hA});
    exp_q.push_back(8'hef);
    exp_q.push_back(8'hbe);
    while (!s_req_ready) @(negedge clk);
    s_req_valid = 1'b1; s_req_write = 1'b1; s_req_addr = 4'hA; s_req_data = 16'hbeef;
    s_tx_ready = 1'b1;
    @(negedge clk);
    s_req_valid = 1'b0;
    done = 0; sent_ack = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (i > 0) @(negedge clk);
      s_rx_valid = 1'b0;
      if (s_rsp_valid) done = 1;
      else begin
        if (got_q.size() == 3 && !sent_ack) begin
          s_rx_valid = 1'b1; s_rx_byte = ACK; sent_ack = 1;
        end
        if (s_tx_valid && s_tx_ready) got_q.push_back(s_tx_byte);
      end
    end
    s_rx_valid = 1'b0;
    total++;
    ok = (got_q.size() == exp_q.size());
    if (ok) for (int k = 0; k < exp_q.size(); k++) if (got_q[k] !== exp_q[k]) ok = 0;
    if (!ok) begin
      bad++;
      $display("FAIL p16_stream: got %0d bytes first=%h want %0d bytes first=%h",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q.size(), exp_q[0]);
    end
    total++;
    if (!done || s_rsp_timeout !== 1'b0 || s_rsp_data !== 16'h0000) begin
      bad++;
      $display("FAIL p16_rsp: got done=%b timeout=%b data=%h want 1 0 0000",
               done, s_rsp_timeout, s_rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat;
    bit wr, silent, bp;
    int naks;
    for (int r = 0; r < 16; r++) begin
      wr = $urandom_range(0, 1);
      naks = wr ? $urandom_range(0, 4) : 0;
      silent = !wr && ($urandom_range(0, 5) == 0);
      bp = $urandom_range(0, 1);
      run_txn("random", wr, 7'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
              naks, silent, bp, lat);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_retry();
    test_exhaust();
    test_backpressure_reset();
    test_param16();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
